// File: rtl/cache_control.sv
// Control FSM for the 2-way write-back, write-allocate L1 cache.
// Drives datapath enables and the pmem writeback/fill handshake.
module cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 ishit_w1,
  input  logic                 ishit_w2,
  input  logic                 isdirty_w1,
  input  logic                 isdirty_w2,
  input  logic                 lru_out,
  output logic                 load_dirty_w1,
  output logic                 load_dirty_w2,
  output logic                 load_valid_w1,
  output logic                 load_valid_w2,
  output logic                 load_tag_w1,
  output logic                 load_tag_w2,
  output logic                 load_datastore_w1,
  output logic                 load_datastore_w2,
  output logic                 load_lru,
  output logic                 datastore_in_mux_sel,
  output logic [1:0]           pmem_address_mux_sel,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   victim_q;
  logic   miss_pending_q;
  logic   req, hit, vic_dirty;
  logic   hit_ev, miss_ev, wb_ev;

  assign req       = mem_read | mem_write;
  assign hit       = ishit_w1 | ishit_w2;
  assign vic_dirty = lru_out ? isdirty_w2 : isdirty_w1;

  always_comb begin
    state_d              = state_q;
    mem_resp             = 1'b0;
    pmem_read            = 1'b0;
    pmem_write           = 1'b0;
    load_dirty_w1        = 1'b0;
    load_dirty_w2        = 1'b0;
    load_valid_w1        = 1'b0;
    load_valid_w2        = 1'b0;
    load_tag_w1          = 1'b0;
    load_tag_w2          = 1'b0;
    load_datastore_w1    = 1'b0;
    load_datastore_w2    = 1'b0;
    load_lru             = 1'b0;
    datastore_in_mux_sel = 1'b0;
    pmem_address_mux_sel = 2'b10;
    hit_ev               = 1'b0;
    miss_ev              = 1'b0;
    wb_ev                = 1'b0;
    // Outputs are forced idle while reset is held, even with a request.
    if (rst_n) begin
      unique case (state_q)
        CHECK: begin
          if (req && hit) begin
            mem_resp = 1'b1;
            hit_ev   = 1'b1;
            load_lru = (lru_out == ishit_w2);
            if (mem_write) begin
              load_datastore_w1 = ~ishit_w2;
              load_dirty_w1     = ~ishit_w2;
              load_datastore_w2 = ishit_w2;
              load_dirty_w2     = ishit_w2;
            end
          end else if (req) begin
            miss_ev = 1'b1;
            state_d = vic_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          pmem_write           = 1'b1;
          pmem_address_mux_sel = {1'b0, victim_q};
          if (pmem_resp) begin
            wb_ev   = 1'b1;
            state_d = ALLOCATE;
          end
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            datastore_in_mux_sel = 1'b1;
            load_datastore_w1    = ~victim_q;
            load_tag_w1          = ~victim_q;
            load_valid_w1        = ~victim_q;
            load_datastore_w2    = victim_q;
            load_tag_w2          = victim_q;
            load_valid_w2        = victim_q;
            state_d              = CHECK;
          end
        end
        default: state_d = CHECK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= CHECK;
      victim_q       <= 1'b0;
      miss_pending_q <= 1'b0;
      hit_count      <= '0;
      miss_count     <= '0;
      wb_count       <= '0;
    end else begin
      state_q <= state_d;
      if (miss_ev) begin
        victim_q       <= lru_out;
        miss_pending_q <= 1'b1;
        miss_count     <= miss_count + CNT_WIDTH'(1);
      end
      // The hit that completes a fill is not a new hit.
      if (hit_ev) begin
        miss_pending_q <= 1'b0;
        if (!miss_pending_q)
          hit_count <= hit_count + CNT_WIDTH'(1);
      end
      if (wb_ev)
        wb_count <= wb_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control: randomized transactions
// against a per-transaction latency/enable/counter model.
module tb_cache_control;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_read, mem_write, mem_resp;
  logic pmem_read, pmem_write, pmem_resp;
  logic ishit_w1, ishit_w2, isdirty_w1, isdirty_w2, lru_out;
  logic load_dirty_w1, load_dirty_w2;
  logic load_valid_w1, load_valid_w2;
  logic load_tag_w1, load_tag_w2;
  logic load_datastore_w1, load_datastore_w2;
  logic load_lru, datastore_in_mux_sel;
  logic [1:0] pmem_address_mux_sel;
  logic [15:0] hit_count, miss_count, wb_count;

  cache_control #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp),
    .ishit_w1(ishit_w1), .ishit_w2(ishit_w2),
    .isdirty_w1(isdirty_w1), .isdirty_w2(isdirty_w2),
    .lru_out(lru_out),
    .load_dirty_w1(load_dirty_w1), .load_dirty_w2(load_dirty_w2),
    .load_valid_w1(load_valid_w1), .load_valid_w2(load_valid_w2),
    .load_tag_w1(load_tag_w1), .load_tag_w2(load_tag_w2),
    .load_datastore_w1(load_datastore_w1),
    .load_datastore_w2(load_datastore_w2),
    .load_lru(load_lru),
    .datastore_in_mux_sel(datastore_in_mux_sel),
    .pmem_address_mux_sel(pmem_address_mux_sel),
    .hit_count(hit_count), .miss_count(miss_count),
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat; int wb; int rd;
    logic [9:0] rv; logic [9:0] fv;
    logic vic;
    int hc; int mc; int wc;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int passed = 0;
  bit mon_en = 1'b0;
  int m_hc = 0, m_mc = 0, m_wc = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, req, $time);
  endtask

  function automatic logic [9:0] ev(bit lru, bit w, bit ds,
                                    bit dty, bit tv, bit dsel);
    logic [3:0] wv;
    wv = {ds, dty, tv, tv};
    return {lru, w ? 4'b0 : wv, w ? wv : 4'b0, dsel};
  endfunction

  function automatic logic [9:0] obs();
    return {load_lru,
            load_datastore_w1, load_dirty_w1, load_tag_w1, load_valid_w1,
            load_datastore_w2, load_dirty_w2, load_tag_w2, load_valid_w2,
            datastore_in_mux_sel};
  endfunction

  // Monitor: accumulates what the DUT did during a transaction and
  // compares it with the queued expectation on each mem_resp.
  int o_cyc = 0, o_wb = 0, o_rd = 0;
  exp_t e;
  logic w1_any, w2_any;
  always @(negedge clk) begin
    if (mon_en) begin
      w1_any = load_dirty_w1 | load_valid_w1 | load_tag_w1
             | load_datastore_w1;
      w2_any = load_dirty_w2 | load_valid_w2 | load_tag_w2
             | load_datastore_w2;
      chk("pmem_excl", {31'b0, pmem_read & pmem_write}, 0);
      chk("one_way", {31'b0, w1_any & w2_any}, 0);
      if (mem_read | mem_write) o_cyc++;
      if (pmem_write) begin
        o_wb++;
        if (exp_q.size() > 0)
          chk("wb_sel", {30'b0, pmem_address_mux_sel},
              {31'b0, exp_q[0].vic});
      end
      if (pmem_read) begin
        o_rd++;
        chk("rd_sel", {30'b0, pmem_address_mux_sel}, 2);
        if (pmem_resp && exp_q.size() > 0)
          chk("fill_en", {22'b0, obs()}, {22'b0, exp_q[0].fv});
      end
      if (mem_resp) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_resp got=1 want=0 t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("latency", o_cyc, e.lat);
          chk("wb_cycles", o_wb, e.wb);
          chk("rd_cycles", o_rd, e.rd);
          chk("resp_en", {22'b0, obs()}, {22'b0, e.rv});
          chk("hit_count", {16'b0, hit_count}, e.hc);
          chk("miss_count", {16'b0, miss_count}, e.mc);
          chk("wb_count", {16'b0, wb_count}, e.wc);
        end
        o_cyc = 0; o_wb = 0; o_rd = 0;
      end
    end
  end

  // kind: 0 = hit way 1, 1 = hit way 2, 2 = miss
  task automatic txn(bit wr, int kind, bit lru, bit d1, bit d2,
                     int m, int n, bit lru2);
    exp_t x;
    bit h, dirty, lru_hit, filled, done;
    int pcnt, cyc;
    dirty = lru ? d2 : d1;
    if (kind < 2) begin
      h = (kind == 1);
      lru_hit = lru;
      x.lat = 1; x.wb = 0; x.rd = 0;
      x.hc = m_hc; x.mc = m_mc; x.wc = m_wc;
      m_hc++;
    end else begin
      h = lru;
      lru_hit = lru2;
      x.wb = dirty ? m : 0;
      x.rd = n;
      x.lat = 2 + x.wb + n;
      m_mc++;
      if (dirty) m_wc++;
      x.hc = m_hc; x.mc = m_mc; x.wc = m_wc;
    end
    x.vic = lru;
    x.rv = ev(lru_hit == h, h, wr, wr, 1'b0, 1'b0);
    x.fv = ev(1'b0, lru, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(x);
    @(posedge clk); #1;
    mem_write = wr;
    mem_read = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    ishit_w1 = (kind == 0);
    ishit_w2 = (kind == 1);
    lru_out = lru;
    isdirty_w1 = d1;
    isdirty_w2 = d2;
    filled = 0; done = 0; pcnt = 0; cyc = 0;
    while (!done && cyc < 300) begin
      #1;
      if (pmem_write) begin
        pcnt++; pmem_resp = (pcnt >= m);
      end else if (pmem_read) begin
        pcnt++; pmem_resp = (pcnt >= n);
      end else pmem_resp = 1'b0;
      @(negedge clk);
      if (pmem_read && pmem_resp) filled = 1;
      if (pmem_resp) pcnt = 0;
      if (mem_resp) done = 1;
      cyc++;
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (done) begin
        mem_read = 0; mem_write = 0;
        ishit_w1 = 0; ishit_w2 = 0;
      end else if (filled) begin
        ishit_w1 = ~lru; ishit_w2 = lru;
        lru_out = lru2;
      end else if (kind == 2) begin
        lru_out = 1'($urandom_range(0, 1));
      end
    end
    if (!done) begin
      total++;
      $display("FAIL txn_timeout got=%0d want=%0d", cyc, x.lat);
      mem_read = 0; mem_write = 0;
    end
  endtask

  initial begin
    rst_n = 0; mem_read = 1; mem_write = 0; pmem_resp = 0;
    ishit_w1 = 0; ishit_w2 = 1; lru_out = 1;
    isdirty_w1 = 0; isdirty_w2 = 0;
    repeat (2) @(negedge clk);
    chk("rst_resp", {31'b0, mem_resp}, 0);
    chk("rst_en", {22'b0, obs()}, 0);
    chk("rst_pmem", {30'b0, pmem_read, pmem_write}, 0);
    chk("rst_sel", {30'b0, pmem_address_mux_sel}, 2);
    chk("rst_cnt", {hit_count, miss_count | wb_count}, 0);
    rst_n = 1; mem_read = 0; ishit_w2 = 0;
    mon_en = 1;

    txn(0, 1, 1, 0, 0, 1, 1, 0);
    txn(0, 1, 0, 0, 0, 1, 1, 0);
    txn(1, 0, 1, 0, 0, 1, 1, 0);
    txn(0, 2, 0, 0, 1, 1, 3, 1);
    txn(0, 2, 1, 0, 1, 2, 2, 0);
    txn(1, 2, 1, 1, 1, 3, 1, 1);
    for (int i = 0; i < 40; i++)
      txn(1'($urandom_range(0, 1)), $urandom_range(0, 2),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom_range(1, 4),
          $urandom_range(1, 4), 1'($urandom_range(0, 1)));

    chk("q_empty", exp_q.size(), 0);
    chk("end_hits", {16'b0, hit_count}, m_hc);
    chk("end_miss", {16'b0, miss_count}, m_mc);
    chk("end_wb", {16'b0, wb_count}, m_wc);

    mon_en = 0;
    @(posedge clk); #1;
    mem_read = 1; lru_out = 0;
    isdirty_w1 = 0; isdirty_w2 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pmem_read) break;
    end
    chk("alloc_seen", {31'b0, pmem_read}, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_pmem", {30'b0, pmem_read, pmem_write}, 0);
    chk("arst_cnt", {hit_count, miss_count | wb_count}, 0);
    chk("arst_sel", {30'b0, pmem_address_mux_sel}, 2);
    @(negedge clk);
    rst_n = 1; mem_read = 0;
    #1;
    chk("post_idle", {29'b0, mem_resp, pmem_read, pmem_write}, 0);
    @(posedge clk); #1;
    mem_read = 1; ishit_w1 = 1; lru_out = 0;
    #1;
    chk("post_hit_resp", {31'b0, mem_resp}, 1);
    chk("post_hit_lru", {31'b0, load_lru}, 1);
    @(posedge clk); #1;
    mem_read = 0; ishit_w1 = 0;
    chk("post_hit_cnt", {16'b0, hit_count}, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
